// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32I control sequencer with req/ack memory handshake and bus timeout.
// Define CORE_SEQ_PERF_CNT_EN to enable the cycles/stalls performance counters.
module core_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go_contr,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic                 comp,
    input  logic                 mem_ack,
    output logic                 irEn,
    output logic                 pcEn,
    output logic                 aluSrc,
    output logic                 regWrite,
    output logic                 isByte,
    output logic                 isHalf,
    output logic                 isWord,
    output logic                 memRead,
    output logic                 memWrite,
    output logic [1:0]           pc_select,
    output logic [1:0]           memToReg,
    output logic                 mem_req,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic [CNT_WIDTH-1:0] stalls
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;

    state_t               r_state, w_next;
    logic [TW-1:0]        r_to;
    logic                 r_done, r_fault;
    logic [CNT_WIDTH-1:0] r_instret;
    logic                 w_retire, w_req, w_timeout, w_go;
    logic                 w_alu, w_op, w_branch, w_jal, w_jalr, w_load, w_store, w_sys, w_legal, w_bad_size;
    logic                 w_unused;

    assign w_unused   = ^{func7, func3[2]};
    assign w_op       = opcode == 7'b0110011;
    assign w_alu      = w_op || opcode == 7'b0010011 || opcode == 7'b0110111 || opcode == 7'b0010111;
    assign w_branch   = opcode == 7'b1100011;
    assign w_jal      = opcode == 7'b1101111;
    assign w_jalr     = opcode == 7'b1100111;
    assign w_load     = opcode == 7'b0000011;
    assign w_store    = opcode == 7'b0100011;
    assign w_sys      = opcode == 7'b1110011;
    assign w_legal    = w_alu | w_branch | w_jal | w_jalr | w_load | w_store | w_sys;
    assign w_bad_size = (w_load | w_store) & (func3[1:0] == 2'b11);

    assign w_req     = r_state == FETCH || r_state == MEM;
    assign w_timeout = w_req && !mem_ack && r_to == TW'(MEM_TIMEOUT - 1);
    assign w_go      = go_contr && (r_state == IDLE || r_state == HALT || r_state == FAULT);
    assign busy      = !(r_state == IDLE || r_state == HALT || r_state == FAULT);
    assign done      = r_done;
    assign fault     = r_fault;
    assign instret   = r_instret;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_to      <= '0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_to      <= (w_req && !mem_ack && !w_timeout) ? r_to + TW'(1) : '0;
            r_done    <= (w_next == HALT) | (r_done & !w_go);
            r_fault   <= (w_next == FAULT) | (r_fault & !w_go);
            r_instret <= r_instret + CNT_WIDTH'(w_retire);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        irEn      = 1'b0;
        pcEn      = 1'b0;
        aluSrc    = 1'b0;
        regWrite  = 1'b0;
        isByte    = 1'b0;
        isHalf    = 1'b0;
        isWord    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        pc_select = 2'b00;
        memToReg  = 2'b00;
        mem_req   = 1'b0;
        case (r_state)
            IDLE, HALT, FAULT: w_next = go_contr ? FETCH : r_state;
            FETCH: begin
                mem_req = 1'b1;
                memRead = 1'b1;
                isWord  = 1'b1;
                irEn    = mem_ack;
                w_next  = mem_ack ? DECODE : w_timeout ? FAULT : FETCH;
            end
            DECODE: w_next = (!w_legal || w_bad_size) ? FAULT : w_sys ? HALT : EXEC;
            EXEC: begin
                aluSrc    = !(w_op || w_branch);
                w_next    = (w_load || w_store) ? MEM : FETCH;
                w_retire  = !(w_load || w_store);
                pcEn      = !(w_load || w_store);
                regWrite  = w_alu | w_jal | w_jalr;
                memToReg  = (w_jal || w_jalr) ? 2'b10 : 2'b00;
                pc_select = w_jalr ? 2'b10 : (w_jal || (w_branch && comp)) ? 2'b01 : 2'b00;
            end
            MEM: begin
                mem_req  = 1'b1;
                memRead  = w_load;
                memWrite = w_store;
                isByte   = func3[1:0] == 2'b00;
                isHalf   = func3[1:0] == 2'b01;
                isWord   = func3[1:0] == 2'b10;
                pcEn     = mem_ack & w_store;
                w_retire = mem_ack & w_store;
                w_next   = mem_ack ? (w_load ? WB : FETCH) : w_timeout ? FAULT : MEM;
            end
            WB: begin
                regWrite = 1'b1;
                memToReg = 2'b01;
                pcEn     = 1'b1;
                w_retire = 1'b1;
                w_next   = FETCH;
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycles, r_stalls;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycles <= '0;
            r_stalls <= '0;
        end else begin
            r_cycles <= r_cycles + CNT_WIDTH'(busy);
            r_stalls <= r_stalls + CNT_WIDTH'(mem_req & !mem_ack);
        end
    end

    assign cycles = r_cycles;
    assign stalls = r_stalls;
`else
    assign cycles = '0;
    assign stalls = '0;
`endif
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed-vector bench for core_seq_ctrl (MEM_TIMEOUT=4).
module tb_core_seq_ctrl;
    logic        clk, reset, go_contr, comp, mem_ack;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic        irEn, pcEn, aluSrc, regWrite, isByte, isHalf, isWord, memRead, memWrite, mem_req;
    logic        busy, done, fault;
    logic [1:0]  pc_select, memToReg;
    logic [31:0] instret, cycles, stalls;
    logic [13:0] w_ctl;
    int          n_chk = 0, n_fail = 0;

`ifdef CORE_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    core_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .go_contr(go_contr), .opcode(opcode), .func3(func3), .func7(func7),
        .comp(comp), .mem_ack(mem_ack), .irEn(irEn), .pcEn(pcEn), .aluSrc(aluSrc), .regWrite(regWrite),
        .isByte(isByte), .isHalf(isHalf), .isWord(isWord), .memRead(memRead), .memWrite(memWrite),
        .pc_select(pc_select), .memToReg(memToReg), .mem_req(mem_req), .busy(busy), .done(done),
        .fault(fault), .instret(instret), .cycles(cycles), .stalls(stalls)
    );

    assign w_ctl = {irEn, pcEn, aluSrc, regWrite, isByte, isHalf, isWord, memRead, memWrite,
                    pc_select, memToReg, mem_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt(input logic ack, input logic c);
        @(negedge clk);
        mem_ack = ack;
        comp    = c;
        #1;
    endtask

    // Called in a FETCH cycle: zero-wait ack, leaves the bench in DECODE.
    task automatic ins(input logic [6:0] op, input logic [2:0] f3);
        opcode  = op;
        func3   = f3;
        mem_ack = 1'b1;
        nxt(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; go_contr = 1'b0; comp = 1'b0; mem_ack = 1'b0;
        opcode = 7'b0010011; func3 = 3'b000; func7 = 7'b0;
        nxt(0, 0);
        nxt(0, 0);
        chk("rst_ctl", 32'(w_ctl), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_instret", instret, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_stalls", stalls, 0);

        // ADDI with three wait states on fetch
        reset = 1'b1; go_contr = 1'b1;
        nxt(0, 0);
        go_contr = 1'b0;
        chk("f1_req", 32'(mem_req), 1);
        chk("f1_rd", 32'(memRead), 1);
        chk("f1_word", 32'(isWord), 1);
        chk("f1_iren", 32'(irEn), 0);
        chk("f1_busy", 32'(busy), 1);
        nxt(0, 0);
        chk("f2_req", 32'(mem_req), 1);
        nxt(0, 0);
        chk("f3_req", 32'(mem_req), 1);
        nxt(1, 0);
        chk("f4_req", 32'(mem_req), 1);
        chk("f4_iren", 32'(irEn), 1);
        nxt(0, 0);
        chk("dec_req", 32'(mem_req), 0);
        chk("dec_iren", 32'(irEn), 0);
        nxt(0, 0);
        chk("addi_rw", 32'(regWrite), 1);
        chk("addi_pcen", 32'(pcEn), 1);
        chk("addi_sel", 32'(pc_select), 0);
        chk("addi_m2r", 32'(memToReg), 0);
        chk("addi_alusrc", 32'(aluSrc), 1);
        chk("addi_inst0", instret, 0);
        nxt(0, 0);
        chk("addi_inst1", instret, 1);
        chk("addi_stalls", stalls, PERF ? 3 : 0);
        chk("addi_cycles", cycles, PERF ? 6 : 0);

        // BEQ taken then not taken
        ins(7'b1100011, 3'b000);
        nxt(0, 1);
        chk("beq1_sel", 32'(pc_select), 1);
        chk("beq1_pcen", 32'(pcEn), 1);
        chk("beq1_rw", 32'(regWrite), 0);
        chk("beq1_alusrc", 32'(aluSrc), 0);
        nxt(0, 0);
        ins(7'b1100011, 3'b000);
        nxt(0, 0);
        chk("beq0_sel", 32'(pc_select), 0);
        chk("beq0_pcen", 32'(pcEn), 1);
        chk("beq0_rw", 32'(regWrite), 0);
        nxt(0, 0);
        chk("beq_inst", instret, 3);

        // LW with zero-wait fetch and memory
        ins(7'b0000011, 3'b010);
        nxt(0, 0);
        chk("lw_ex_pcen", 32'(pcEn), 0);
        chk("lw_ex_alusrc", 32'(aluSrc), 1);
        nxt(1, 0);
        chk("lw_mem_req", 32'(mem_req), 1);
        chk("lw_mem_rd", 32'(memRead), 1);
        chk("lw_mem_word", 32'(isWord), 1);
        chk("lw_mem_wr", 32'(memWrite), 0);
        nxt(0, 0);
        chk("lw_wb_m2r", 32'(memToReg), 1);
        chk("lw_wb_rw", 32'(regWrite), 1);
        chk("lw_wb_pcen", 32'(pcEn), 1);
        chk("lw_wb_req", 32'(mem_req), 0);
        nxt(0, 0);
        chk("lw_inst", instret, 4);

        // SB
        ins(7'b0100011, 3'b000);
        nxt(0, 0);
        nxt(1, 0);
        chk("sb_byte", 32'(isByte), 1);
        chk("sb_word", 32'(isWord), 0);
        chk("sb_wr", 32'(memWrite), 1);
        chk("sb_rd", 32'(memRead), 0);
        chk("sb_pcen", 32'(pcEn), 1);
        nxt(0, 0);
        chk("sb_inst", instret, 5);
        chk("sb_next_req", 32'(mem_req), 1);

        // JAL, JALR
        ins(7'b1101111, 3'b000);
        nxt(0, 0);
        chk("jal_rw", 32'(regWrite), 1);
        chk("jal_m2r", 32'(memToReg), 2);
        chk("jal_sel", 32'(pc_select), 1);
        nxt(0, 0);
        ins(7'b1100111, 3'b000);
        nxt(0, 0);
        chk("jalr_sel", 32'(pc_select), 2);
        chk("jalr_m2r", 32'(memToReg), 2);
        nxt(0, 0);
        chk("jalr_inst", instret, 7);

        // Illegal opcode faults; go restarts
        ins(7'b1111111, 3'b000);
        nxt(0, 0);
        chk("ill_fault", 32'(fault), 1);
        chk("ill_busy", 32'(busy), 0);
        chk("ill_ctl", 32'(w_ctl), 0);
        go_contr = 1'b1;
        nxt(0, 0);
        go_contr = 1'b0;
        chk("ill_go_fault", 32'(fault), 0);

        // Fetch timeout after 4 request cycles
        chk("to1_req", 32'(mem_req), 1);
        nxt(0, 0);
        nxt(0, 0);
        nxt(0, 0);
        chk("to4_req", 32'(mem_req), 1);
        nxt(0, 0);
        chk("to_fault", 32'(fault), 1);
        chk("to_req", 32'(mem_req), 0);
        chk("to_busy", 32'(busy), 0);
        chk("to_inst", instret, 7);
        go_contr = 1'b1;
        nxt(0, 0);
        go_contr = 1'b0;
        chk("to_go_fault", 32'(fault), 0);
        chk("to_go_req", 32'(mem_req), 1);

        // SYSTEM halts
        ins(7'b1110011, 3'b000);
        nxt(0, 0);
        chk("sys_done", 32'(done), 1);
        chk("sys_busy", 32'(busy), 0);
        chk("sys_ctl", 32'(w_ctl), 0);
        chk("sys_inst", instret, 7);
        go_contr = 1'b1;
        nxt(0, 0);
        go_contr = 1'b0;
        chk("sys_go_done", 32'(done), 0);

        // Reset asserted during a MEM request
        ins(7'b0000011, 3'b010);
        nxt(0, 0);
        nxt(0, 0);
        chk("rm_req", 32'(mem_req), 1);
        reset = 1'b0;
        nxt(0, 0);
        chk("rm_req0", 32'(mem_req), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_inst", instret, 0);
        reset = 1'b1;
        nxt(0, 0);
        chk("rm_idle_ctl", 32'(w_ctl), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
